// File: rtl/nios2_debug_slave_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one command becomes UIR/CDR/SDR/UDR/RTI.
// Define NIOS2_DEBUG_SCAN_CAPTURE_EN to keep the vji_tdo capture path and a live rsp_data.
//
// state | meaning
// IDLE  | waiting for a command; tck parked low; also hosts the one-clk rsp_valid pulse
// UIR   | update-IR tck cycle, vji_ir_in already presented
// CDR   | capture-DR tck cycle
// SDR   | SR_WIDTH tck cycles shifting vji_tdi out and vji_tdo in, LSB first
// UDR   | update-DR tck cycle
// RTI   | run-test-idle tck cycle, then response
module nios2_debug_slave_scan_master #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIV_W = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
  localparam int BIT_W = (SR_WIDTH > 2) ? $clog2(SR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_cycle_end;
  logic                tck_rise;

  // The tck cycle timer counts down; terminal count 0 marks the last clk of a tck cycle.
  assign tck_cycle_end = (div_q == '0);
  assign tck_rise      = (div_q == DIV_HALF);

  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign vji_ir_in = ir_q;
  assign vji_tck   = (state_q != ST_IDLE) && (div_q < DIV_HALF);
  assign vji_tdi   = (state_q == ST_SDR) && shift_q[0];
  assign vji_uir   = (state_q == ST_UIR);
  assign vji_cdr   = (state_q == ST_CDR);
  assign vji_sdr   = (state_q == ST_SDR);
  assign vji_udr   = (state_q == ST_UDR);
  assign vji_rti   = (state_q == ST_RTI);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ir_d        = ir_q;
    rsp_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        state_d = ST_UIR;
        div_d   = DIV_LOAD;
        bit_d   = '0;
        ir_d    = cmd_ir;
        shift_d = cmd_data;
      end
    end else begin
      div_d = tck_cycle_end ? DIV_LOAD : div_q - 1'b1;
      if (tck_cycle_end) begin
        case (state_q)
          ST_UIR: state_d = ST_CDR;
          ST_CDR: begin
            state_d = ST_SDR;
            bit_d   = '0;
          end
          ST_SDR: begin
            // Shifting on the cycle boundary keeps vji_tdi stable across the whole tck cycle.
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = ST_UDR;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          ST_UDR: state_d = ST_RTI;
          ST_RTI: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ir_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ir_q        <= ir_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef NIOS2_DEBUG_SCAN_CAPTURE_EN
  logic [SR_WIDTH-1:0] capture_q, capture_d;
  logic [SR_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    capture_d  = capture_q;
    rsp_data_d = rsp_data_q;
    // Each new bit enters at the top so the first bit received ends up in bit 0.
    if (state_q == ST_SDR && tck_rise) begin
      capture_d = {vji_tdo, capture_q[SR_WIDTH-1:1]};
    end
    if (state_q == ST_RTI && tck_cycle_end) begin
      rsp_data_d = capture_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      capture_q  <= capture_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
`else
  logic unused_tdo;
  logic unused_tck_rise;
  assign unused_tdo      = vji_tdo;
  assign unused_tck_rise = tck_rise;
  assign rsp_data        = '0;
`endif

endmodule
